// File: rtl/commit_trace_tx.sv
// commit_trace_tx: samples per-cycle commit events (register writeback,
// store, halt), queues one entry per active cycle and serializes the
// entries as REG/STORE/HALT records of 16-bit words on a valid/ready stream.
// Optional build macro TRACE_CYCLE_EN adds a free-running cycle stamp word
// after every record header.
module commit_trace_tx #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_regwrite,
    input  logic [3:0]       ev_reg,
    input  logic [15:0]      ev_wdata,
    input  logic             ev_memwrite,
    input  logic [15:0]      ev_addr,
    input  logic [15:0]      ev_mdata,
    input  logic             ev_halt,
    input  logic [15:0]      ev_pc,
    output logic             tx_valid,
    output logic [15:0]      tx_data,
    output logic             tx_last,
    input  logic             tx_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic        regwrite;
        logic [3:0]  rd;
        logic [15:0] wdata;
        logic        memwrite;
        logic [15:0] addr;
        logic [15:0] mdata;
        logic        halt;
        logic [15:0] pc;
`ifdef TRACE_CYCLE_EN
        logic [15:0] stamp;
`endif
    } entry_t;

    localparam int     EW         = $bits(entry_t);
    localparam entry_t ENTRY_ZERO = {EW{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
`ifdef TRACE_CYCLE_EN
        ST_STAMP = 3'd2,
`endif
        ST_W1    = 3'd3,
        ST_W2    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        REC_REG   = 2'd0,
        REC_STORE = 2'd1,
        REC_HALT  = 2'd2
    } rec_t;

    // First record to emit for an entry (entries always carry at least one flag)
    function automatic rec_t first_rec(input entry_t e);
        rec_t r;
        if (e.regwrite) begin
            r = REC_REG;
        end else if (e.memwrite) begin
            r = REC_STORE;
        end else begin
            r = REC_HALT;
        end
        return r;
    endfunction

    // Whether another record follows record r inside the same entry
    function automatic logic has_next(input rec_t r, input entry_t e);
        logic n;
        case (r)
            REC_REG:   n = e.memwrite | e.halt;
            REC_STORE: n = e.halt;
            default:   n = 1'b0;
        endcase
        return n;
    endfunction

    // Record that follows r inside the entry (only meaningful when has_next)
    function automatic rec_t next_rec(input rec_t r, input entry_t e);
        rec_t n;
        case (r)
            REC_REG: begin
                if (e.memwrite) begin
                    n = REC_STORE;
                end else begin
                    n = REC_HALT;
                end
            end
            default: n = REC_HALT;
        endcase
        return n;
    endfunction

    // Word carried on the bus for a given position inside a record
    function automatic logic [15:0] word_data(input state_t st, input rec_t r,
                                              input entry_t e, input logic [15:0] inst);
        logic [15:0] w;
        case (st)
            ST_HDR: begin
                case (r)
                    REC_REG:   w = {4'h1, e.rd, 8'h00};
                    REC_STORE: w = 16'h2000;
                    REC_HALT:  w = 16'hF000;
                    default:   w = 16'h0000;
                endcase
            end
`ifdef TRACE_CYCLE_EN
            ST_STAMP: w = e.stamp;
`endif
            ST_W1: begin
                case (r)
                    REC_REG:   w = e.wdata;
                    REC_STORE: w = e.addr;
                    REC_HALT:  w = e.pc;
                    default:   w = 16'h0000;
                endcase
            end
            ST_W2: begin
                case (r)
                    REC_STORE: w = e.mdata;
                    REC_HALT:  w = inst;
                    default:   w = 16'h0000;
                endcase
            end
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Capture stage
    logic             cap_vld_q, cap_vld_d;
    entry_t           cap_q, cap_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
`ifdef TRACE_CYCLE_EN
    logic [15:0]      cyc_q, cyc_d;
`endif

    // Entry storage
    entry_t           fifo_mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             hslot_vld_q, hslot_vld_d;
    entry_t           hslot_q, hslot_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Serializer
    state_t           state_q, state_d;
    rec_t             rec_q, rec_d;
    logic             tx_valid_q, tx_valid_d;
    logic [15:0]      tx_data_q, tx_data_d;
    logic             tx_last_q, tx_last_d;
    logic             done_q, done_d;

    logic             full_s, room_s, pending_s, next_pend_s, hs_s;
    logic             push_s, pop_fifo_s, hold_halt_s, drop_s, rec_end_s;
    entry_t           head_s, next_ent_s, ent_sel_s;
    logic [15:0]      inst16_s;

    assign hs_s     = tx_valid_q & tx_ready;
    assign inst16_s = 16'(inst_cnt_q);

    // Register the commit events; instruction count includes the capturing cycle
    always_comb begin
        cap_vld_d  = 1'b0;
        cap_d      = cap_q;
        halted_d   = halted_q;
        inst_cnt_d = inst_cnt_q;
`ifdef TRACE_CYCLE_EN
        cyc_d      = cyc_q + 16'd1;
`endif
        if (!halted_q && (ev_regwrite || ev_memwrite || ev_halt)) begin
            cap_vld_d      = 1'b1;
            cap_d.regwrite = ev_regwrite;
            cap_d.rd       = ev_reg;
            cap_d.wdata    = ev_wdata;
            cap_d.memwrite = ev_memwrite;
            cap_d.addr     = ev_addr;
            cap_d.mdata    = ev_mdata;
            cap_d.halt     = ev_halt;
            cap_d.pc       = ev_pc;
`ifdef TRACE_CYCLE_EN
            cap_d.stamp    = cyc_q;
`endif
            halted_d       = ev_halt;
            if (ev_regwrite && ev_memwrite) begin
                inst_cnt_d = inst_cnt_q + CNT_W'(2);
            end else begin
                inst_cnt_d = inst_cnt_q + CNT_W'(1);
            end
        end else begin
            cap_vld_d = 1'b0;
        end
    end

    // Head-of-queue view: FIFO first, halt slot once the FIFO has drained
    always_comb begin
        full_s      = (count_q == CW'(DEPTH));
        pending_s   = (count_q != CW'(0)) || hslot_vld_q;
        next_pend_s = (count_q > CW'(1)) || ((count_q == CW'(1)) && hslot_vld_q);
        if (count_q != CW'(0)) begin
            head_s = fifo_mem_q[rd_ptr_q];
        end else begin
            head_s = hslot_q;
        end
        if (count_q > CW'(1)) begin
            next_ent_s = fifo_mem_q[rd_ptr_q + AW'(1)];
        end else begin
            next_ent_s = hslot_q;
        end
    end

    // Record sequencer: next state, pop decision and the next bus word
    always_comb begin
        state_d    = state_q;
        rec_d      = rec_q;
        pop_fifo_s = 1'b0;
        rec_end_s  = 1'b0;
        ent_sel_s  = head_s;
        case (state_q)
            ST_IDLE: begin
                if (pending_s) begin
                    state_d = ST_HDR;
                    rec_d   = first_rec(head_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (hs_s) begin
`ifdef TRACE_CYCLE_EN
                    state_d = ST_STAMP;
`else
                    state_d = ST_W1;
`endif
                end else begin
                    state_d = ST_HDR;
                end
            end
`ifdef TRACE_CYCLE_EN
            ST_STAMP: begin
                if (hs_s) begin
                    state_d = ST_W1;
                end else begin
                    state_d = ST_STAMP;
                end
            end
`endif
            ST_W1: begin
                if (hs_s && (rec_q == REC_REG)) begin
                    rec_end_s = 1'b1;
                end else if (hs_s) begin
                    state_d = ST_W2;
                end else begin
                    state_d = ST_W1;
                end
            end
            ST_W2: begin
                if (hs_s) begin
                    rec_end_s = 1'b1;
                end else begin
                    state_d = ST_W2;
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase

        // A finished record moves to the next record, the next entry, or idles
        if (rec_end_s) begin
            if (rec_q == REC_HALT) begin
                state_d = ST_DONE;
            end else if (has_next(rec_q, head_s)) begin
                state_d = ST_HDR;
                rec_d   = next_rec(rec_q, head_s);
            end else begin
                pop_fifo_s = (count_q != CW'(0));
                if (next_pend_s) begin
                    state_d   = ST_HDR;
                    rec_d     = first_rec(next_ent_s);
                    ent_sel_s = next_ent_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end else begin
            pop_fifo_s = 1'b0;
        end

        if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 16'h0000;
            tx_last_d  = 1'b0;
        end else begin
            tx_valid_d = 1'b1;
            tx_data_d  = word_data(state_d, rec_d, ent_sel_s, inst16_s);
            tx_last_d  = (state_d == ST_W2) || ((state_d == ST_W1) && (rec_d == REC_REG));
        end
        done_d = (state_d == ST_DONE);
    end

    // Queue bookkeeping: a same-cycle pop makes room for the push; halts never drop
    always_comb begin
        room_s      = !full_s || pop_fifo_s;
        push_s      = cap_vld_q && room_s;
        hold_halt_s = cap_vld_q && !room_s && cap_q.halt;
        drop_s      = cap_vld_q && !room_s && !cap_q.halt;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        hslot_vld_d = hslot_vld_q;
        hslot_d     = hslot_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_fifo_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_fifo_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (hold_halt_s) begin
            hslot_vld_d = 1'b1;
            hslot_d     = cap_q;
        end else begin
            hslot_vld_d = hslot_vld_q;
        end
        if (drop_s) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Entry storage write port (contents need no reset; occupancy is tracked by count)
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= cap_q;
        end
    end

    // State registers; reset aborts any record in flight immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_vld_q   <= 1'b0;
            cap_q       <= ENTRY_ZERO;
            halted_q    <= 1'b0;
            inst_cnt_q  <= {CNT_W{1'b0}};
`ifdef TRACE_CYCLE_EN
            cyc_q       <= 16'd0;
`endif
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            hslot_vld_q <= 1'b0;
            hslot_q     <= ENTRY_ZERO;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= {CNT_W{1'b0}};
            state_q     <= ST_IDLE;
            rec_q       <= REC_REG;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 16'h0000;
            tx_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cap_vld_q   <= cap_vld_d;
            cap_q       <= cap_d;
            halted_q    <= halted_d;
            inst_cnt_q  <= inst_cnt_d;
`ifdef TRACE_CYCLE_EN
            cyc_q       <= cyc_d;
`endif
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hslot_vld_q <= hslot_vld_d;
            hslot_q     <= hslot_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            state_q     <= state_d;
            rec_q       <= rec_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            tx_last_q   <= tx_last_d;
            done_q      <= done_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_last  = tx_last_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign done     = done_q;

endmodule
